// File: rtl/mux_pkg.sv
// Shared helpers for the registered word select: select-width math and occupancy width.
package mux_pkg;

    localparam int OCC_W = 2;

    // Constant-evaluable ceil(log2), used to size the select port from NUM_IN.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
        return sel < num_in;
    endfunction

endpackage

// File: rtl/skid_reg2.sv
// Two-entry output storage (main register + skid register) with valid/ready and a flush
// that drops held beats without touching the data registers.
module skid_reg2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             skid_valid
);

    logic [WIDTH-1:0] skid_data;
    logic             accept;

    // Ready depends only on registered state and flush, never on out_ready.
    assign in_ready = ~skid_valid & ~flush;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Main is free this edge; an older skid beat always goes first.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data;
                end
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-to-1 word select with registered, back-pressured output and a sticky out-of-range flag.
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH*NUM_IN-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err,
    input  logic                    err_clr,
    output logic [OCC_W-1:0]        occ
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;
    logic             accept;
    logic             skid_valid;

    // Out-of-range selects yield an all-zero word rather than X or a wrapped index.
    function automatic logic [WIDTH-1:0] sel_word(input logic [WIDTH*NUM_IN-1:0] data,
                                                  input logic [SEL_W-1:0]        sel);
        logic [WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                result = data[i*WIDTH +: WIDTH];
            end
        end
        return result;
    endfunction

    assign sel_data = sel_word(in_data, in_sel);
    assign sel_bad  = ~sel_in_range(32'(in_sel), NUM_IN);
    assign accept   = in_valid & in_ready;

    skid_reg2 #(
        .WIDTH(WIDTH)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (sel_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .skid_valid(skid_valid)
    );

    // A new error wins over a same-cycle clear so no bad beat goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && sel_bad) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    assign occ = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: three instances (NUM_IN=4, 3, 2) sharing clock and reset.
module tb_mux_sel_pipe;

    logic clk;
    logic rst_n;

    logic [127:0] d4_in_data;
    logic [1:0]   d4_in_sel;
    logic         d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_flush, d4_sel_err, d4_err_clr;
    logic [31:0]  d4_out_data;
    logic [1:0]   d4_occ;

    logic [95:0]  d3_in_data;
    logic [1:0]   d3_in_sel;
    logic         d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_flush, d3_sel_err, d3_err_clr;
    logic [31:0]  d3_out_data;
    logic [1:0]   d3_occ;

    logic [63:0]  d2_in_data;
    logic [0:0]   d2_in_sel;
    logic         d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_flush, d2_sel_err, d2_err_clr;
    logic [31:0]  d2_out_data;
    logic [1:0]   d2_occ;

    int testsRun;
    int testsFailed;

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4_in_data), .in_sel(d4_in_sel),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .out_data(d4_out_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .flush(d4_flush),
        .sel_err(d4_sel_err), .err_clr(d4_err_clr), .occ(d4_occ)
    );

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_in_sel),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .flush(d3_flush),
        .sel_err(d3_sel_err), .err_clr(d3_err_clr), .occ(d3_occ)
    );

    mux_sel_pipe dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_sel(d2_in_sel),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .out_data(d2_out_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .flush(d2_flush),
        .sel_err(d2_sel_err), .err_clr(d2_err_clr), .occ(d2_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge, so outputs read here reflect the previous rising edge.
    task automatic applyStimulus();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  streamSel [4];
        logic [31:0] streamExp [4];
        logic [63:0] legacyData [3];
        logic [0:0]  legacySel  [3];
        logic [31:0] legacyExp  [3];

        streamSel = '{2'd2, 2'd0, 2'd3, 2'd1};
        streamExp = '{32'h33, 32'h11, 32'h44, 32'h22};
        legacyData = '{{32'hBBBB0002, 32'hAAAA0001}, {32'hBBBB0004, 32'hAAAA0003}, {32'hBBBB0006, 32'hAAAA0005}};
        legacySel  = '{1'b0, 1'b1, 1'b1};
        legacyExp  = '{32'hAAAA0001, 32'hBBBB0004, 32'hBBBB0006};

        testsRun = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        d4_in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        d4_in_sel = '0; d4_in_valid = 0; d4_out_ready = 1; d4_flush = 0; d4_err_clr = 0;
        d3_in_data = {32'h33, 32'h22, 32'h11};
        d3_in_sel = '0; d3_in_valid = 0; d3_out_ready = 1; d3_flush = 0; d3_err_clr = 0;
        d2_in_data = '0;
        d2_in_sel = '0; d2_in_valid = 0; d2_out_ready = 1; d2_flush = 0; d2_err_clr = 0;

        // Reset state
        repeat (2) applyStimulus();
        checkOutput("rst_out_valid", d4_out_valid, 1'b0);
        checkOutput("rst_out_data", d4_out_data, 32'h0);
        checkOutput("rst_occ", d4_occ, 2'd0);
        checkOutput("rst_sel_err", d4_sel_err, 1'b0);
        checkOutput("rst_in_ready", d4_in_ready, 1'b1);
        rst_n = 1'b1;
        applyStimulus();

        // Streaming at full rate with 1-cycle latency
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                checkOutput($sformatf("stream_data%0d", i - 1), d4_out_data, streamExp[i-1]);
                checkOutput($sformatf("stream_valid%0d", i - 1), d4_out_valid, 1'b1);
            end
            if (i < 4) begin
                d4_in_valid = 1;
                d4_in_sel = streamSel[i];
                #1 checkOutput($sformatf("stream_ready%0d", i), d4_in_ready, 1'b1);
            end else begin
                d4_in_valid = 0;
            end
            applyStimulus();
        end
        checkOutput("stream_drained_valid", d4_out_valid, 1'b0);
        checkOutput("stream_hold_data", d4_out_data, 32'h22);

        // Backpressure: A=0x11, B=0x22 stored, C=0x33 held off until drain
        d4_out_ready = 0;
        d4_in_valid = 1; d4_in_sel = 2'd0;
        applyStimulus();
        checkOutput("bp_occ1", d4_occ, 2'd1);
        checkOutput("bp_ready1", d4_in_ready, 1'b1);
        d4_in_sel = 2'd1;
        applyStimulus();
        checkOutput("bp_occ2", d4_occ, 2'd2);
        checkOutput("bp_ready0", d4_in_ready, 1'b0);
        checkOutput("bp_mainA", d4_out_data, 32'h11);
        d4_in_sel = 2'd2;
        applyStimulus();
        checkOutput("bp_stall_occ", d4_occ, 2'd2);
        checkOutput("bp_stall_data", d4_out_data, 32'h11);
        d4_out_ready = 1;
        applyStimulus();
        checkOutput("bp_B", d4_out_data, 32'h22);
        checkOutput("bp_B_occ", d4_occ, 2'd1);
        checkOutput("bp_B_ready", d4_in_ready, 1'b1);
        applyStimulus();
        checkOutput("bp_C", d4_out_data, 32'h33);
        checkOutput("bp_C_valid", d4_out_valid, 1'b1);
        d4_in_valid = 0;
        applyStimulus();
        checkOutput("bp_done_valid", d4_out_valid, 1'b0);
        checkOutput("bp_done_occ", d4_occ, 2'd0);

        // Flush with two beats held and a beat offered
        d4_out_ready = 0;
        d4_in_valid = 1; d4_in_sel = 2'd3;
        applyStimulus();
        d4_in_sel = 2'd1;
        applyStimulus();
        checkOutput("fl_pre_occ", d4_occ, 2'd2);
        d4_flush = 1; d4_in_sel = 2'd0;
        #1 checkOutput("fl_ready", d4_in_ready, 1'b0);
        applyStimulus();
        checkOutput("fl_occ", d4_occ, 2'd0);
        checkOutput("fl_valid", d4_out_valid, 1'b0);
        checkOutput("fl_data", d4_out_data, 32'h44);
        d4_flush = 0; d4_in_valid = 0; d4_out_ready = 1;
        #1 checkOutput("fl_ready_after", d4_in_ready, 1'b1);
        applyStimulus();
        checkOutput("fl_no_ghost", d4_out_valid, 1'b0);

        // Out-of-range select on NUM_IN=3
        d3_in_valid = 1; d3_in_sel = 2'd1;
        applyStimulus();
        checkOutput("bad_good_data", d3_out_data, 32'h22);
        checkOutput("bad_good_err", d3_sel_err, 1'b0);
        d3_in_sel = 2'd3;
        applyStimulus();
        checkOutput("bad_data", d3_out_data, 32'h0);
        checkOutput("bad_valid", d3_out_valid, 1'b1);
        checkOutput("bad_err", d3_sel_err, 1'b1);
        d3_in_valid = 0;
        applyStimulus();
        checkOutput("bad_sticky", d3_sel_err, 1'b1);
        d3_err_clr = 1;
        applyStimulus();
        checkOutput("bad_clr", d3_sel_err, 1'b0);
        d3_in_valid = 1; d3_in_sel = 2'd3;
        applyStimulus();
        checkOutput("bad_clr_collide", d3_sel_err, 1'b1);
        d3_err_clr = 0; d3_in_valid = 0;
        applyStimulus();

        // Default parameters against the legacy 2:1 select, one cycle later
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                checkOutput($sformatf("legacy%0d", i - 1), d2_out_data, legacyExp[i-1]);
            end
            if (i < 3) begin
                d2_in_valid = 1;
                d2_in_data = legacyData[i];
                d2_in_sel = legacySel[i];
            end else begin
                d2_in_valid = 0;
            end
            applyStimulus();
        end
        checkOutput("legacy_err", d2_sel_err, 1'b0);

        // Asynchronous reset while a beat is stalled in dut4 and dut3 holds an error
        d4_out_ready = 0;
        d4_in_valid = 1; d4_in_sel = 2'd2;
        applyStimulus();
        d4_in_valid = 0;
        checkOutput("ar_pre_valid", d4_out_valid, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", d4_out_valid, 1'b0);
        checkOutput("ar_data", d4_out_data, 32'h0);
        checkOutput("ar_occ", d4_occ, 2'd0);
        checkOutput("ar_ready", d4_in_ready, 1'b1);
        checkOutput("ar_err", d3_sel_err, 1'b0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
